// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned XLEN          = 32;
  localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0000;
  localparam int unsigned MEM_BYTES_DEF = 512;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage : ifetch_pkg

// File: rtl/ifetch_npc.sv
// Next-PC selection and fetch legality check for the fetch stage.
module ifetch_npc
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] MEM_BYTES = 32'(MEM_BYTES_DEF)
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_target,
  output logic [XLEN-1:0] o_next_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_illegal
);

  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_plus4 = i_pc + 32'd4;
  assign o_pc_plus4 = w_pc_plus4;

  // A redirect target is accepted blindly; it is only checked once it becomes the fetch PC.
  assign o_next_pc  = i_br_valid ? i_br_target : w_pc_plus4;
  assign o_illegal  = (i_pc[1:0] != 2'b00) || (i_pc >= MEM_BYTES);

endmodule : ifetch_npc

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory and fills the IF/ID register.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     MEM_BYTES = MEM_BYTES_DEF,
  parameter logic [XLEN-1:0] NOP       = NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] im_addr,
  input  logic [XLEN-1:0] im_data,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [XLEN-1:0] fetch_cnt
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pc4;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;
  logic [XLEN-1:0] r_fetch_cnt;

  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_illegal;
  logic            w_adv;
  logic            w_redirect;
  logic            w_take_fault;
  logic            w_fetch;

  ifetch_npc #(
    .MEM_BYTES (32'(MEM_BYTES))
  ) u_npc (
    .i_pc        (r_pc),
    .i_br_valid  (br_valid),
    .i_br_target (br_target),
    .o_next_pc   (w_next_pc),
    .o_pc_plus4  (w_pc_plus4),
    .o_illegal   (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority within RUN: redirect, then fault detection, then advance; otherwise hold.
  always_comb begin
    w_state_next = r_state;
    w_adv        = 1'b0;
    w_redirect   = 1'b0;
    w_take_fault = 1'b0;
    w_fetch      = 1'b0;
    case (r_state)
      RUN: begin
        w_adv = !r_valid || id_ready;
        if (br_valid) begin
          w_redirect = 1'b1;
        end else if (w_adv && w_illegal) begin
          w_take_fault = 1'b1;
          w_state_next = FAULT;
        end else if (w_adv) begin
          w_fetch = 1'b1;
        end
      end
      FAULT: begin
        w_state_next = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_valid      <= 1'b0;
      r_inst       <= NOP;
      r_if_pc      <= '0;
      r_if_pc4     <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_fetch_cnt  <= '0;
    end else begin
      if (w_redirect) begin
        r_pc    <= w_next_pc;
        r_valid <= 1'b0;
        r_inst  <= NOP;
      end else if (w_take_fault) begin
        r_fault      <= 1'b1;
        r_fault_addr <= r_pc;
        r_valid      <= 1'b0;
        r_inst       <= NOP;
      end else if (w_fetch) begin
        r_inst      <= im_data;
        r_if_pc     <= r_pc;
        r_if_pc4    <= w_pc_plus4;
        r_valid     <= 1'b1;
        r_pc        <= w_next_pc;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign im_addr    = r_pc;
  assign if_valid   = r_valid;
  assign if_inst    = r_inst;
  assign if_pc      = r_if_pc;
  assign if_pc4     = r_if_pc4;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign fetch_cnt  = r_fetch_cnt;

endmodule : ifetch

// File: tb/tb_ifetch.sv
// Directed self-checking bench for the fetch stage against a 128-word memory model.
module tb_ifetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        br_valid;
  logic [31:0] br_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [128];
  int          assertCount;
  int          failCount;

  ifetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (512),
    .NOP       (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_addr    (im_addr),
    .im_data    (im_data),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return a marker word that must never reach decode.
  assign im_data = (im_addr < 32'd512) ? mem[im_addr[8:2]] : 32'hDEAD_BEEF;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    checkOutput({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    checkOutput({tag, "_pc"}, if_pc, pc);
    checkOutput({tag, "_pc4"}, if_pc4, pc + 32'd4);
    checkOutput({tag, "_inst"}, if_inst, 32'h1000_0000 + (pc >> 2));
    checkOutput({tag, "_cnt"}, fetch_cnt, cnt);
  endtask

  task automatic checkFault(input string tag, input logic [31:0] addr, input logic [31:0] cnt);
    checkOutput({tag, "_fault"}, {31'd0, fault}, 32'd1);
    checkOutput({tag, "_faddr"}, fault_addr, addr);
    checkOutput({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    checkOutput({tag, "_inst"}, if_inst, 32'h0000_0000);
    checkOutput({tag, "_cnt"}, fetch_cnt, cnt);
    checkOutput({tag, "_imaddr"}, im_addr, addr);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    rst_n     = 1'b0;
    br_valid  = 1'b0;
    br_target = 32'h0;
    id_ready  = 1'b1;

    stepClk();
    stepClk();
    checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_inst", if_inst, 32'h0);
    checkOutput("rst_imaddr", im_addr, 32'h0);
    checkOutput("rst_cnt", fetch_cnt, 32'h0);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
    rst_n = 1'b1;

    // Streaming fetch, one word per cycle.
    stepClk();
    checkFetch("seq0", 32'h0, 32'd1);
    checkOutput("seq0_imaddr", im_addr, 32'h4);
    stepClk();
    checkFetch("seq1", 32'h4, 32'd2);
    stepClk();
    checkFetch("seq2", 32'h8, 32'd3);

    // Backpressure holds the IF/ID register and the PC.
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stepClk();
      checkFetch("stall", 32'h8, 32'd3);
      checkOutput("stall_imaddr", im_addr, 32'hC);
    end
    id_ready = 1'b1;
    stepClk();
    checkFetch("resume", 32'hC, 32'd4);

    // Redirect while stalled.
    id_ready  = 1'b0;
    br_valid  = 1'b1;
    br_target = 32'h40;
    stepClk();
    checkOutput("redir_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("redir_inst", if_inst, 32'h0);
    checkOutput("redir_imaddr", im_addr, 32'h40);
    checkOutput("redir_cnt", fetch_cnt, 32'd4);
    br_valid = 1'b0;
    id_ready = 1'b1;
    stepClk();
    checkFetch("redir_fetch", 32'h40, 32'd5);

    // Run off the end of memory.
    br_valid  = 1'b1;
    br_target = 32'h1F8;
    stepClk();
    checkOutput("end_redir_valid", {31'd0, if_valid}, 32'd0);
    br_valid = 1'b0;
    stepClk();
    checkFetch("end0", 32'h1F8, 32'd6);
    stepClk();
    checkFetch("end1", 32'h1FC, 32'd7);
    checkOutput("end1_imaddr", im_addr, 32'h200);
    stepClk();
    checkFault("endflt", 32'h200, 32'd7);
    br_valid  = 1'b1;
    br_target = 32'h0;
    stepClk();
    checkFault("endflt_br", 32'h200, 32'd7);
    br_valid = 1'b0;

    // Asynchronous reset from FAULT, observed before the next clock edge.
    rst_n = 1'b0;
    #2;
    checkOutput("arst_fault", {31'd0, fault}, 32'd0);
    checkOutput("arst_faddr", fault_addr, 32'h0);
    checkOutput("arst_imaddr", im_addr, 32'h0);
    checkOutput("arst_cnt", fetch_cnt, 32'h0);
    checkOutput("arst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("arst_pc", if_pc, 32'h0);
    checkOutput("arst_pc4", if_pc4, 32'h0);
    #3;
    rst_n = 1'b1;
    stepClk();
    checkFetch("post_rst", 32'h0, 32'd1);

    // Misaligned redirect faults when fetched; later redirects are ignored.
    br_valid  = 1'b1;
    br_target = 32'h42;
    stepClk();
    checkOutput("mis_redir_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("mis_redir_imaddr", im_addr, 32'h42);
    br_valid = 1'b0;
    stepClk();
    checkFault("misflt", 32'h42, 32'd1);
    br_valid  = 1'b1;
    br_target = 32'h80;
    stepClk();
    checkFault("misflt_br", 32'h42, 32'd1);
    br_valid = 1'b0;
    stepClk();
    checkFault("misflt_hold", 32'h42, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_ifetch
